// File: rtl/ps2_codes_pkg.sv
// ---------------------------------------------------------------------------
// ps2_codes_pkg
// Shared constants for the PS/2 Set-2 scan-code decoder: scan-code values
// for prefixes and special keys, ASCII control characters, the 2-bit FSM
// state encoding, and a helper that flags keyboard protocol bytes which
// carry no key information.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_codes_pkg;

  // Scan codes
  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] LSHIFT       = 8'h12;
  localparam logic [7:0] RSHIFT       = 8'h59;
  localparam logic [7:0] CAPS         = 8'h58;
  localparam logic [7:0] ENTER        = 8'h5A;
  localparam logic [7:0] BKSP         = 8'h66;
  localparam logic [7:0] SPACE        = 8'h29;

  // ASCII control characters
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Keyboard status/response bytes (BAT ok, ACK, resend, echo, errors).
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
           (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// ---------------------------------------------------------------------------
// ps2_ascii_lut
// Purely combinational Set-2 make-code to ASCII translation.
// Ports:
//   code  [7:0] in  : make code (no prefix)
//   shift       in  : shift currently held
//   caps        in  : caps-lock toggle state
//   hit         out : code maps to a printable/control character
//   ascii [7:0] out : translated character (0x00 when no hit)
// Letters use shift XOR caps for case; digits and punctuation use shift
// only; space, enter and backspace ignore both modifiers.
// ---------------------------------------------------------------------------
module ps2_ascii_lut
  import ps2_codes_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic       hit,
  output logic [7:0] ascii
);

  logic       upper;
  logic [7:0] lower;
  logic       is_letter;

  assign upper = shift ^ caps;

  always_comb begin
    hit       = 1'b1;
    ascii     = 8'h00;
    lower     = 8'h00;
    is_letter = 1'b0;
    case (code)
      8'h1C: begin is_letter = 1'b1; lower = 8'h61; end // a
      8'h32: begin is_letter = 1'b1; lower = 8'h62; end // b
      8'h21: begin is_letter = 1'b1; lower = 8'h63; end // c
      8'h23: begin is_letter = 1'b1; lower = 8'h64; end // d
      8'h24: begin is_letter = 1'b1; lower = 8'h65; end // e
      8'h2B: begin is_letter = 1'b1; lower = 8'h66; end // f
      8'h34: begin is_letter = 1'b1; lower = 8'h67; end // g
      8'h33: begin is_letter = 1'b1; lower = 8'h68; end // h
      8'h43: begin is_letter = 1'b1; lower = 8'h69; end // i
      8'h3B: begin is_letter = 1'b1; lower = 8'h6A; end // j
      8'h42: begin is_letter = 1'b1; lower = 8'h6B; end // k
      8'h4B: begin is_letter = 1'b1; lower = 8'h6C; end // l
      8'h3A: begin is_letter = 1'b1; lower = 8'h6D; end // m
      8'h31: begin is_letter = 1'b1; lower = 8'h6E; end // n
      8'h44: begin is_letter = 1'b1; lower = 8'h6F; end // o
      8'h4D: begin is_letter = 1'b1; lower = 8'h70; end // p
      8'h15: begin is_letter = 1'b1; lower = 8'h71; end // q
      8'h2D: begin is_letter = 1'b1; lower = 8'h72; end // r
      8'h1B: begin is_letter = 1'b1; lower = 8'h73; end // s
      8'h2C: begin is_letter = 1'b1; lower = 8'h74; end // t
      8'h3C: begin is_letter = 1'b1; lower = 8'h75; end // u
      8'h2A: begin is_letter = 1'b1; lower = 8'h76; end // v
      8'h1D: begin is_letter = 1'b1; lower = 8'h77; end // w
      8'h22: begin is_letter = 1'b1; lower = 8'h78; end // x
      8'h35: begin is_letter = 1'b1; lower = 8'h79; end // y
      8'h1A: begin is_letter = 1'b1; lower = 8'h7A; end // z
      8'h16: ascii = shift ? 8'h21 : 8'h31; // 1 !
      8'h1E: ascii = shift ? 8'h40 : 8'h32; // 2 @
      8'h26: ascii = shift ? 8'h23 : 8'h33; // 3 #
      8'h25: ascii = shift ? 8'h24 : 8'h34; // 4 $
      8'h2E: ascii = shift ? 8'h25 : 8'h35; // 5 %
      8'h36: ascii = shift ? 8'h5E : 8'h36; // 6 ^
      8'h3D: ascii = shift ? 8'h26 : 8'h37; // 7 &
      8'h3E: ascii = shift ? 8'h2A : 8'h38; // 8 *
      8'h46: ascii = shift ? 8'h28 : 8'h39; // 9 (
      8'h45: ascii = shift ? 8'h29 : 8'h30; // 0 )
      8'h41: ascii = shift ? 8'h3C : 8'h2C; // , <
      8'h49: ascii = shift ? 8'h3E : 8'h2E; // . >
      8'h4A: ascii = shift ? 8'h3F : 8'h2F; // / ?
      SPACE: ascii = 8'h20;
      ENTER: ascii = CR;
      BKSP:  ascii = BS;
      default: hit = 1'b0;
    endcase
    // Clearing bit 5 maps a lowercase letter onto its uppercase form.
    if (is_letter) begin
      ascii = upper ? (lower & 8'hDF) : lower;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
// Consumes the PS/2 received-byte stream, tracks Set-2 prefixes (E0 / F0)
// and modifier state, and emits one ASCII character per printable key press
// as a single-cycle pulse registered one cycle after the byte strobe.
// Ports:
//   inclock          in  : system clock, rising edge
//   resetn           in  : synchronous active-low reset
//   scan_code  [7:0] in  : received byte, qualified by scan_valid
//   scan_valid       in  : one-cycle byte strobe
//   ascii_char [7:0] out : last emitted character, held between pulses
//   ascii_valid      out : one-cycle pulse marking a new character
//   shift_active     out : left or right shift held
//   caps_lock        out : caps-lock toggle state
// Parameter CAPS_LOCK_SUPPORT: 1 = 0x58 toggles caps_lock, 0 = ignored.
// Optional macro PS2_TYPEMATIC_SUPPRESS_EN: suppresses typematic repeats of
// the most recently pressed mapped key until its break code is seen.
// ---------------------------------------------------------------------------
module ps2_scancode_decoder
  import ps2_codes_pkg::*;
#(
  parameter int CAPS_LOCK_SUPPORT = 1
) (
  input  logic       inclock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] ascii_char,
  output logic       ascii_valid,
  output logic       shift_active,
  output logic       caps_lock
);

  logic [1:0] state, state_nxt;
  logic       shift_l, shift_l_nxt;
  logic       shift_r, shift_r_nxt;
  logic       caps_nxt;
  logic       emit;
  logic [7:0] emit_char;
  logic       lut_hit;
  logic [7:0] lut_ascii;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
  logic [7:0] held_code, held_code_nxt;
`endif

  assign shift_active = shift_l | shift_r;

  ps2_ascii_lut u_lut (
    .code  (scan_code),
    .shift (shift_active),
    .caps  (caps_lock),
    .hit   (lut_hit),
    .ascii (lut_ascii)
  );

  always_comb begin
    state_nxt   = state;
    shift_l_nxt = shift_l;
    shift_r_nxt = shift_r;
    caps_nxt    = caps_lock;
    emit        = 1'b0;
    emit_char   = lut_ascii;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    held_code_nxt = held_code;
`endif
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == PREFIX_BREAK) begin
            state_nxt = ST_BRK;
          end else if (scan_code == PREFIX_EXT) begin
            state_nxt = ST_EXT;
          end else if (scan_code == LSHIFT) begin
            shift_l_nxt = 1'b1;
          end else if (scan_code == RSHIFT) begin
            shift_r_nxt = 1'b1;
          end else if (scan_code == CAPS) begin
            if (CAPS_LOCK_SUPPORT != 0) begin
              caps_nxt = ~caps_lock;
            end
          end else if (!is_ignored(scan_code) && lut_hit) begin
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
            // A repeat of the key still held is auto-repeat, not a new press.
            if (scan_code != held_code) begin
              emit          = 1'b1;
              held_code_nxt = scan_code;
            end
`else
            emit = 1'b1;
`endif
          end
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          if (scan_code == LSHIFT) begin
            shift_l_nxt = 1'b0;
          end else if (scan_code == RSHIFT) begin
            shift_r_nxt = 1'b0;
          end else if (scan_code == PREFIX_EXT) begin
            // Treat a stray E0 as the start of a new extended sequence.
            state_nxt = ST_EXT;
          end else if (scan_code == PREFIX_BREAK) begin
            state_nxt = ST_BRK;
          end
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
          if (scan_code == held_code) begin
            held_code_nxt = 8'h00;
          end
`endif
        end
        ST_EXT: begin
          state_nxt = ST_IDLE;
          if (scan_code == PREFIX_BREAK) begin
            state_nxt = ST_EXT_BRK;
          end else if (scan_code == PREFIX_EXT) begin
            state_nxt = ST_EXT;
          end else if (scan_code == ENTER) begin
            emit      = 1'b1;
            emit_char = CR;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Registered output stage: pulse appears the cycle after the strobe.
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      caps_lock   <= 1'b0;
      ascii_valid <= 1'b0;
      ascii_char  <= 8'h00;
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
      held_code   <= 8'h00;
`endif
    end else begin
      state       <= state_nxt;
      shift_l     <= shift_l_nxt;
      shift_r     <= shift_r_nxt;
      caps_lock   <= caps_nxt;
      ascii_valid <= emit;
      if (emit) begin
        ascii_char <= emit_char;
      end
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
      held_code   <= held_code_nxt;
`endif
    end
  end

endmodule
